fir_sequencer: RTL and testbench
================================

FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 4, the number of filter taps (legal 2..7).
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port data_ready  input  1  new sample available at the datapath input.
REQ-005 SHALL have port load_coeff  input  1  coefficient available at the datapath input.
REQ-006 SHALL have port overflow  input  1  datapath flag reflecting the previous cycle's op.
REQ-007 SHALL have port cnt_up  output  1  one-cycle pulse per accepted sample, drives sample-counter count enable.
REQ-008 SHALL have port clear  output  1  one-cycle pulse that restarts the sample counter.
REQ-009 SHALL have port modwait  output  1  busy indicator.
REQ-010 SHALL have port op  output  3  datapath operation.
REQ-011 SHALL have ports src1, src2, dest  output  4 each  register-file addresses.
REQ-012 SHALL have port err  output  1  sticky error indicator.

Function
REQ-013 Register map SHALL be: r0 accumulator; r1..rNUM_TAPS sample history, r1 newest; r8..r(7+NUM_TAPS) coefficients; r15 product temp.
REQ-014 States SHALL be IDLE, SHIFT, STORE, CLRACC, MUL, ACC, DONE and EIDLE, plus LOADC and WAITC when the coefficient-load feature is compiled in.
REQ-015 From IDLE or EIDLE, data_ready=1 SHALL go to SHIFT; data_ready SHALL have priority over load_coeff.
REQ-016 SHIFT SHALL last NUM_TAPS-1 cycles, issuing COPY rk->r(k+1) with k descending from NUM_TAPS-1 to 1, then go to STORE.
REQ-017 STORE SHALL issue LOAD1 with dest=r1 if data_ready=1, then go to CLRACC; otherwise it SHALL issue NOP and go to EIDLE.
REQ-018 CLRACC SHALL issue SUB r0=r0-r0 and assert cnt_up for exactly this cycle.
REQ-019 For tap i=0..NUM_TAPS-1, MUL SHALL issue r15=r(1+i)*r(8+i) and ACC SHALL issue r0=r0+r15.
REQ-020 After the last ACC the state SHALL go to DONE (NOP), then to IDLE.
REQ-021 In MUL, ACC and DONE, overflow=1 SHALL force EIDLE on the next edge and set err.
REQ-022 err SHALL be cleared only on leaving EIDLE via data_ready.
REQ-023 modwait SHALL be registered and high in every state except IDLE and EIDLE.
REQ-024 For a sample, modwait SHALL be high for exactly 3*NUM_TAPS+2 cycles (14 cycles at NUM_TAPS=4), starting the edge after data_ready is seen.
REQ-025 In IDLE and EIDLE, op SHALL be NOP and src1, src2 and dest SHALL be 0.
REQ-026 Inputs arriving while modwait=1 SHALL be ignored, except data_ready in STORE and overflow per REQ-021.

Reset
REQ-027 On n_rst=0 the block SHALL immediately enter IDLE, with all outputs 0 and the tap and coefficient indices 0, including mid-sequence.
REQ-028 The first rising edge after n_rst rises SHALL evaluate IDLE transitions normally.

Configuration
REQ-029 Macro FIR_SEQ_COEFF_LOAD_EN, when defined, SHALL enable LOADC and WAITC.
REQ-030 With the macro, IDLE plus load_coeff=1 (data_ready=0) SHALL go to LOADC: issue LOAD2 with dest=r(8+cidx), set modwait=1, increment cidx.
REQ-031 With the macro, LOADC SHALL go to WAITC, which SHALL hold until load_coeff=0 and then go to IDLE.
REQ-032 With the macro, when cidx wraps from NUM_TAPS-1 to 0, clear SHALL pulse for one cycle in WAITC entry.
REQ-033 Without the macro, load_coeff SHALL be ignored, clear SHALL be tied to 0, and the coefficients SHALL be externally preloaded.

Structure
REQ-034 Package fir_seq_pkg SHALL hold the state enum, the op encoding (NOP=0, COPY=1, LOAD1=2, LOAD2=3, ADD=4, SUB=5, MUL=6) and the register-map constants (ACC_REG=0, COEF_BASE=8, TEMP_REG=15).
REQ-035 The tap/shift index SHALL be an instance of flex_counter (4-bit), cleared on entry to SHIFT and MUL.

Verification
REQ-036 Reset, then data_ready pulse at NUM_TAPS=4 -> COPY r3->r4, r2->r3, r1->r2, LOAD1 r1, SUB r0, then 4x (MUL, ADD); cnt_up single pulse; modwait high 14 cycles.
REQ-037 data_ready dropped before STORE -> EIDLE, err=1, cnt_up never pulses; next data_ready -> err=0, full sequence runs.
REQ-038 overflow=1 during the second ACC -> EIDLE next edge, err=1, modwait=0, op=NOP.
REQ-039 With the macro, 4 load_coeff pulses -> LOAD2 to r8..r11, with clear pulsing once after the fourth; load_coeff held high -> exactly one LOAD2.
REQ-040 data_ready and load_coeff both high in IDLE -> sample path taken; n_rst low in MUL -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fir_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_seq_pkg
// Description : FIR sequencer states, datapath op encoding and register map.
//               LOADC/WAITC exist only with FIR_SEQ_COEFF_LOAD_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_seq_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        SHIFT  = 4'd1,
        STORE  = 4'd2,
        CLRACC = 4'd3,
        MUL    = 4'd4,
        ACC    = 4'd5,
        DONE   = 4'd6,
        EIDLE  = 4'd7
`ifdef FIR_SEQ_COEFF_LOAD_EN
        ,
        LOADC  = 4'd8,
        WAITC  = 4'd9
`endif
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_COPY  = 3'd1,
        OP_LOAD1 = 3'd2,
        OP_LOAD2 = 3'd3,
        OP_ADD   = 3'd4,
        OP_SUB   = 3'd5,
        OP_MUL   = 3'd6
    } op_t;

    localparam logic [3:0] ACC_REG   = 4'd0;
    localparam logic [3:0] COEF_BASE = 4'd8;
    localparam logic [3:0] TEMP_REG  = 4'd15;

endpackage
`default_nettype wire

// File: rtl/fir_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_sequencer_if
// Description : Handshake and datapath-control bundle between sequencer and datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_sequencer_if;
    logic       data_ready;
    logic       load_coeff;
    logic       overflow;
    logic       cnt_up;
    logic       clear;
    logic       modwait;
    logic       err;
    logic [2:0] op;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;

    modport master (
        input  data_ready, load_coeff, overflow,
        output cnt_up, clear, modwait, err, op, src1, src2, dest
    );

    modport slave (
        output data_ready, load_coeff, overflow,
        input  cnt_up, clear, modwait, err, op, src1, src2, dest
    );
endinterface
`default_nettype wire

// File: rtl/fir_sequencer_flex_counter.sv
`default_nettype none
// ============================================================================
// Module      : flex_counter
// Description : Clearable up-counter that wraps to 0 after reaching rollover_val.
// Revision    : 1.0 - initial release
// ============================================================================
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  wire logic                    clk,
    input  wire logic                    n_rst,
    input  wire logic                    clear,
    input  wire logic                    count_enable,
    input  wire logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic      [NUM_CNT_BITS-1:0] count_out,
    output logic                         rollover_flag
);
    logic [NUM_CNT_BITS-1:0] r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_count <= '0;
        else if (clear)
            r_count <= '0;
        else if (count_enable)
            r_count <= rollover_flag ? '0 : r_count + 1'b1;
    end

    assign count_out     = r_count;
    assign rollover_flag = (r_count == rollover_val);
endmodule
`default_nettype wire

// File: rtl/fir_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir_sequencer
// Description : Control FSM sequencing shift/load/multiply-accumulate ops of a
//               NUM_TAPS FIR datapath. FIR_SEQ_COEFF_LOAD_EN adds coefficient load.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sequencer
    import fir_seq_pkg::*;
#(
    parameter int NUM_TAPS = 4
) (
    input  wire logic        clk,
    input  wire logic        n_rst,
    fir_sequencer_if.master  bus
);
    localparam logic [3:0] c_taps       = 4'(NUM_TAPS);
    localparam logic [3:0] c_tap_last   = 4'(NUM_TAPS - 1);
    localparam logic [3:0] c_shift_last = 4'(NUM_TAPS - 2);

    state_t     r_state;
    state_t     w_next;
    logic       r_modwait;
    logic       r_err;
    op_t        w_op;
    logic [3:0] w_src1;
    logic [3:0] w_src2;
    logic [3:0] w_dest;
    logic       w_cnt_up;
    logic       w_idx_clear;
    logic       w_idx_en;
    logic       w_idx_last;
    logic [3:0] w_idx;
    logic [3:0] w_idx_roll;

`ifdef FIR_SEQ_COEFF_LOAD_EN
    localparam logic [2:0] c_cidx_last = 3'(NUM_TAPS - 1);
    logic [2:0] r_cidx;
    logic       r_clear;
`endif

    // Same counter walks the shift chain (N-1 steps) and the tap loop (N steps)
    assign w_idx_roll = (r_state == SHIFT) ? c_shift_last : c_tap_last;

    flex_counter #(.NUM_CNT_BITS(4)) u_idx (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (w_idx_clear),
        .count_enable  (w_idx_en),
        .rollover_val  (w_idx_roll),
        .count_out     (w_idx),
        .rollover_flag (w_idx_last)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_modwait <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_modwait <= !((w_next == IDLE) || (w_next == EIDLE));
            if (w_next == EIDLE)
                r_err <= 1'b1;
            else if (r_state == EIDLE)
                r_err <= 1'b0;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_op        = OP_NOP;
        w_src1      = 4'd0;
        w_src2      = 4'd0;
        w_dest      = 4'd0;
        w_cnt_up    = 1'b0;
        w_idx_clear = 1'b0;
        w_idx_en    = 1'b0;
        case (r_state)
            IDLE, EIDLE: begin
                if (bus.data_ready) begin
                    w_next      = SHIFT;
                    w_idx_clear = 1'b1;
                end
`ifdef FIR_SEQ_COEFF_LOAD_EN
                else if ((r_state == IDLE) && bus.load_coeff) begin
                    w_next = LOADC;
                end
`endif
            end
            SHIFT: begin
                w_op     = OP_COPY;
                w_src1   = c_tap_last - w_idx;
                w_dest   = c_taps - w_idx;
                w_idx_en = 1'b1;
                if (w_idx_last)
                    w_next = STORE;
            end
            STORE: begin
                if (bus.data_ready) begin
                    w_op   = OP_LOAD1;
                    w_dest = 4'd1;
                    w_next = CLRACC;
                end else begin
                    w_next = EIDLE;
                end
            end
            CLRACC: begin
                w_op        = OP_SUB;
                w_src1      = ACC_REG;
                w_src2      = ACC_REG;
                w_dest      = ACC_REG;
                w_cnt_up    = 1'b1;
                w_idx_clear = 1'b1;
                w_next      = MUL;
            end
            MUL: begin
                w_op   = OP_MUL;
                w_src1 = 4'd1 + w_idx;
                w_src2 = COEF_BASE + w_idx;
                w_dest = TEMP_REG;
                w_next = bus.overflow ? EIDLE : ACC;
            end
            ACC: begin
                w_op   = OP_ADD;
                w_src1 = ACC_REG;
                w_src2 = TEMP_REG;
                w_dest = ACC_REG;
                if (bus.overflow) begin
                    w_next = EIDLE;
                end else if (w_idx_last) begin
                    w_next = DONE;
                end else begin
                    w_idx_en = 1'b1;
                    w_next   = MUL;
                end
            end
            DONE: begin
                w_next = bus.overflow ? EIDLE : IDLE;
            end
`ifdef FIR_SEQ_COEFF_LOAD_EN
            LOADC: begin
                w_op   = OP_LOAD2;
                w_dest = COEF_BASE + {1'b0, r_cidx};
                w_next = WAITC;
            end
            WAITC: begin
                if (!bus.load_coeff)
                    w_next = IDLE;
            end
`endif
            default: w_next = IDLE;
        endcase
    end

`ifdef FIR_SEQ_COEFF_LOAD_EN
    // clear is registered so it lands on the first WAITC cycle after the wrap
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cidx  <= 3'd0;
            r_clear <= 1'b0;
        end else if (r_state == LOADC) begin
            r_cidx  <= (r_cidx == c_cidx_last) ? 3'd0 : r_cidx + 3'd1;
            r_clear <= (r_cidx == c_cidx_last);
        end else begin
            r_clear <= 1'b0;
        end
    end
    assign bus.clear = r_clear;
`else
    logic w_unused_load_coeff;
    assign w_unused_load_coeff = bus.load_coeff;
    assign bus.clear           = 1'b0;
`endif

    assign bus.op      = w_op;
    assign bus.src1    = w_src1;
    assign bus.src2    = w_src2;
    assign bus.dest    = w_dest;
    assign bus.cnt_up  = w_cnt_up;
    assign bus.modwait = r_modwait;
    assign bus.err     = r_err;
endmodule
`default_nettype wire

// File: tb/tb_fir_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fir_sequencer
// Description : Randomized self-checking bench for fir_sequencer against an op-trace model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_sequencer;
    import fir_seq_pkg::*;

    localparam int N       = 4;
    localparam int SEQ_LEN = 3 * N + 2;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    // Expected per-cycle instruction {op, src1, src2, dest} and cnt_up for one sample
    logic [14:0] exp_ins [SEQ_LEN];
    logic        exp_cnt [SEQ_LEN];

    fir_sequencer_if bus ();

    fir_sequencer #(.NUM_TAPS(N)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [18:0] snap();
        return {bus.op, bus.src1, bus.src2, bus.dest,
                bus.modwait, bus.cnt_up, bus.clear, bus.err};
    endfunction

    task automatic build_model();
        int p = 0;
        for (int k = N - 1; k >= 1; k--) begin
            exp_ins[p] = {OP_COPY, 4'(k), 4'd0, 4'(k + 1)}; exp_cnt[p] = 1'b0; p++;
        end
        exp_ins[p] = {OP_LOAD1, 4'd0, 4'd0, 4'd1}; exp_cnt[p] = 1'b0; p++;
        exp_ins[p] = {OP_SUB, 12'd0};              exp_cnt[p] = 1'b1; p++;
        for (int i = 0; i < N; i++) begin
            exp_ins[p] = {OP_MUL, 4'(1 + i), 4'(8 + i), 4'd15}; exp_cnt[p] = 1'b0; p++;
            exp_ins[p] = {OP_ADD, 4'd0, 4'd15, 4'd0};           exp_cnt[p] = 1'b0; p++;
        end
        exp_ins[p] = {OP_NOP, 12'd0}; exp_cnt[p] = 1'b0;
    endtask

    // ovf_at: trace index where overflow is raised (-1 = none); rel: release reset at start
    task automatic run_sample(input int ovf_at, input logic both, input logic rel);
        int          last;
        logic [18:0] exp;
        last = (ovf_at >= 0) ? ovf_at : SEQ_LEN - 1;
        @(negedge clk);
        if (rel) n_rst = 1'b1;
        bus.data_ready = 1'b1;
        bus.load_coeff = both;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            exp = {exp_ins[c], 1'b1, exp_cnt[c], 1'b0, 1'b0};
            total++;
            if (snap() !== exp) begin
                bad++;
                $display("FAIL sample cyc=%0d got=%h want=%h", c, snap(), exp);
            end
            if (c == N) begin
                bus.data_ready = 1'b0;
                bus.load_coeff = 1'b0;
            end
            if (c == ovf_at) bus.overflow = 1'b1;
        end
        @(negedge clk);
        bus.overflow = 1'b0;
        exp = {15'd0, 1'b0, 1'b0, 1'b0, (ovf_at >= 0)};
        total++;
        if (snap() !== exp) begin
            bad++;
            $display("FAIL sample_end ovf=%0d got=%h want=%h", ovf_at, snap(), exp);
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (snap() !== 19'd0) begin
            bad++;
            $display("FAIL reset got=%h want=%h", snap(), 19'd0);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        total++;
        if (snap() !== 19'd0) begin
            bad++;
            $display("FAIL reset_idle got=%h want=%h", snap(), 19'd0);
        end
    endtask

    task automatic test_sample();
        run_sample(-1, 1'b0, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        run_sample(-1, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        int          d;
        logic [18:0] exp;
        d = $urandom_range(0, N - 1);
        @(negedge clk);
        bus.data_ready = 1'b1;
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            if (c == d) begin
                bus.data_ready = 1'b0;
                #1;
            end
            exp = (c < N - 1) ? {exp_ins[c], 1'b1, 1'b0, 1'b0, 1'b0}
                              : {15'd0, 1'b1, 1'b0, 1'b0, 1'b0};
            total++;
            if (snap() !== exp) begin
                bad++;
                $display("FAIL abort cyc=%0d drop=%0d got=%h want=%h", c, d, snap(), exp);
            end
        end
        repeat ($urandom_range(1, 4)) begin
            @(negedge clk);
            total++;
            if (snap() !== {15'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL abort_eidle got=%h want=%h", snap(), {15'd0, 4'b0001});
            end
        end
        run_sample(-1, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        run_sample(N + 4, 1'b0, 1'b0);
        run_sample(int'($urandom_range(N + 1, SEQ_LEN - 1)), 1'b0, 1'b0);
        run_sample(-1, 1'b0, 1'b0);
    endtask

    task automatic test_priority();
        run_sample(-1, 1'b1, 1'b0);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        bus.data_ready = 1'b1;
        for (int c = 0; c <= N + 1; c++) begin
            @(negedge clk);
            if (c == N) bus.data_ready = 1'b0;
        end
        #2 n_rst = 1'b0;
        #1;
        total++;
        if (snap() !== 19'd0) begin
            bad++;
            $display("FAIL mid_reset got=%h want=%h", snap(), 19'd0);
        end
        run_sample(-1, 1'b0, 1'b1);
    endtask

    task automatic test_coeff();
`ifdef FIR_SEQ_COEFF_LOAD_EN
        int n_load;
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            bus.load_coeff = 1'b1;
            @(negedge clk);
            total++;
            if (snap() !== {OP_LOAD2, 4'd0, 4'd0, 4'(8 + c), 4'b1000}) begin
                bad++;
                $display("FAIL loadc c=%0d got=%h want=%h", c, snap(), {OP_LOAD2, 8'd0, 4'(8 + c), 4'b1000});
            end
            bus.load_coeff = 1'b0;
            @(negedge clk);
            total++;
            if (snap() !== {15'd0, 1'b1, 1'b0, (c == N - 1), 1'b0}) begin
                bad++;
                $display("FAIL waitc c=%0d got=%h want=%h", c, snap(), {15'd0, 1'b1, 1'b0, (c == N - 1), 1'b0});
            end
            @(negedge clk);
            total++;
            if (snap() !== 19'd0) begin
                bad++;
                $display("FAIL loadc_idle c=%0d got=%h want=%h", c, snap(), 19'd0);
            end
        end
        n_load = 0;
        @(negedge clk);
        bus.load_coeff = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.op == OP_LOAD2) n_load++;
        end
        bus.load_coeff = 1'b0;
        @(negedge clk);
        total++;
        if (n_load != 1 || snap() !== 19'd0) begin
            bad++;
            $display("FAIL load_held loads=%0d want=1 got=%h want=%h", n_load, snap(), 19'd0);
        end
`else
        @(negedge clk);
        bus.load_coeff = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (snap() !== 19'd0) begin
                bad++;
                $display("FAIL load_ignored got=%h want=%h", snap(), 19'd0);
            end
        end
        bus.load_coeff = 1'b0;
`endif
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 2) == 0)
                run_sample(int'($urandom_range(N + 1, SEQ_LEN - 1)), 1'($urandom_range(0, 1)), 1'b0);
            else
                run_sample(-1, 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        bus.data_ready = 1'b0;
        bus.load_coeff = 1'b0;
        bus.overflow   = 1'b0;
        build_model();
        test_reset();
        test_sample();
        test_abort();
        test_overflow();
        test_priority();
        test_mid_reset();
        test_coeff();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
